// File: rtl/cla_pkg.sv
// Shared types and defaults for the pipelined carry-lookahead adder/subtractor.
// The op_e encoding is visible at the block boundary, so operand-issue logic must agree with it.
package cla_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBB = 2'd3
  } op_e;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;

  function automatic int cla_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: full lookahead on the internal carries,
// plus the group propagate/generate pair used by the next level of lookahead.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_c,
  output logic [GROUP-1:0] o_sum,
  output logic             o_p,
  output logic             o_g
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  assign o_p = &w_p;

  // Each carry is a flat sum of products, so no carry waits on the carry below it.
  always_comb begin
    logic v_acc;
    logic v_term;
    v_acc  = 1'b0;
    v_term = 1'b0;
    w_c    = '0;
    for (int i = 0; i < GROUP; i++) begin
      v_acc = i_c;
      for (int q = 0; q < i; q++) v_acc = v_acc & w_p[q];
      for (int m = 0; m < i; m++) begin
        v_term = w_g[m];
        for (int q = m + 1; q < i; q++) v_term = v_term & w_p[q];
        v_acc = v_acc | v_term;
      end
      w_c[i] = v_acc;
    end
  end

  always_comb begin
    logic v_term;
    v_term = 1'b0;
    o_g    = 1'b0;
    for (int m = 0; m < GROUP; m++) begin
      v_term = w_g[m];
      for (int q = m + 1; q < GROUP; q++) v_term = v_term & w_p[q];
      o_g = o_g | v_term;
    end
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Slot 0 registers the selected operands; stage k resolves bit slice k from slot k into slot k+1.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int GROUP  = CLA_GROUP,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NG  = cla_groups(WIDTH, GROUP);
  localparam int GPS = NG / STAGES;
  localparam int SW  = WIDTH / STAGES;
  localparam int L   = STAGES - 1;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end
  if (STAGES < 1 || STAGES > NG || (NG % STAGES) != 0) begin : g_bad_stages
    $error("pipelined_cla_adder: STAGES must be in 1..WIDTH/GROUP and divide WIDTH/GROUP");
  end

  logic [STAGES:0]              r_valid;
  logic [STAGES:0][WIDTH-1:0]   r_a;
  logic [STAGES:0][WIDTH-1:0]   r_b;
  logic [STAGES:0][WIDTH-1:0]   r_sum;
  logic [STAGES:0]              r_c;
  logic                         r_cout;
  logic                         r_ovf;
  logic                         r_zero;

  logic [STAGES:0]              w_adv;
  logic [WIDTH-1:0]             w_b_sel;
  logic                         w_c0;
  logic [STAGES-1:0][SW-1:0]    w_slice_sum;
  logic [STAGES-1:0][WIDTH-1:0] w_out_sum;
  logic [STAGES-1:0][GPS-1:0]   w_gp;
  logic [STAGES-1:0][GPS-1:0]   w_gg;
  logic [STAGES-1:0][GPS:0]     w_gc;
  logic                         w_msb_cin;
  logic                         w_unused;

  // Subtraction is a + ~b + 1; for SBB, cin_i is a borrow, so the carry-in is its inverse.
  always_comb begin
    w_b_sel = b_i;
    w_c0    = 1'b0;
    case (op_i)
      SUB:     begin w_b_sel = ~b_i; w_c0 = 1'b1;   end
      ADC:     begin w_b_sel = b_i;  w_c0 = cin_i;  end
      SBB:     begin w_b_sel = ~b_i; w_c0 = ~cin_i; end
      default: begin w_b_sel = b_i;  w_c0 = 1'b0;   end
    endcase
  end

  // A slot advances when it is empty or its successor advances, so bubbles collapse.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = ~r_valid[STAGES] | ready_i;
    for (int k = STAGES - 1; k >= 0; k--) w_adv[k] = ~r_valid[k] | w_adv[k+1];
  end

  assign ready_o = w_adv[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .i_a   (r_a[gi][gi*SW + gj*GROUP +: GROUP]),
        .i_b   (r_b[gi][gi*SW + gj*GROUP +: GROUP]),
        .i_c   (w_gc[gi][gj]),
        .o_sum (w_slice_sum[gi][gj*GROUP +: GROUP]),
        .o_p   (w_gp[gi][gj]),
        .o_g   (w_gg[gi][gj])
      );
    end
  end

  // Second-level lookahead across the groups of one stage, seeded by the registered stage carry.
  always_comb begin
    logic v_acc;
    logic v_term;
    v_acc  = 1'b0;
    v_term = 1'b0;
    w_gc   = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j <= GPS; j++) begin
        v_acc = r_c[k];
        for (int q = 0; q < j; q++) v_acc = v_acc & w_gp[k][q];
        for (int m = 0; m < j; m++) begin
          v_term = w_gg[k][m];
          for (int q = m + 1; q < j; q++) v_term = v_term & w_gp[k][q];
          v_acc = v_acc | v_term;
        end
        w_gc[k][j] = v_acc;
      end
    end
  end

  always_comb begin
    w_out_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_out_sum[k]              = r_sum[k];
      w_out_sum[k][k*SW +: SW]  = w_slice_sum[k];
    end
    // The carry into the MSB is recovered from its sum bit: s = p ^ c.
    w_msb_cin = r_a[L][WIDTH-1] ^ r_b[L][WIDTH-1] ^ w_slice_sum[L][SW-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= valid_i;
        if (valid_i) begin
          r_a[0]   <= a_i;
          r_b[0]   <= w_b_sel;
          r_c[0]   <= w_c0;
          r_sum[0] <= '0;
        end
      end
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k+1]) begin
          r_valid[k+1] <= r_valid[k];
          if (r_valid[k]) begin
            r_a[k+1]   <= r_a[k];
            r_b[k+1]   <= r_b[k];
            r_c[k+1]   <= w_gc[k][GPS];
            r_sum[k+1] <= w_out_sum[k];
          end
        end
      end
      if (w_adv[STAGES] && r_valid[L]) begin
        r_cout <= w_gc[L][GPS];
        r_ovf  <= w_gc[L][GPS] ^ w_msb_cin;
        r_zero <= ~|w_out_sum[L];
      end
    end
  end

  assign valid_o = r_valid[STAGES];
  assign sum_o   = r_sum[STAGES];
  assign cout_o  = r_cout;
  assign ovf_o   = r_ovf;
  assign zero_o  = r_zero;

  // Operands and carry have nothing left to resolve once they reach the output slot.
  assign w_unused = ^{r_a[STAGES], r_b[STAGES], r_c[STAGES]};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomised checks of pipelined_cla_adder (WIDTH=32, GROUP=4, STAGES=2).
// Results are compared as {zero, ovf, cout, sum}.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  op_e         op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cin_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] sum_o;
  logic        cout_o;
  logic        ovf_o;
  logic        zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o),
    .zero_o  (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] res();
    return {zero_o, ovf_o, cout_o, sum_o};
  endfunction

  // Two's-complement arithmetic model; overflow uses the operand-sign rule.
  function automatic logic [34:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [31:0] bb;
    logic        c0;
    logic [32:0] full;
    logic        ovf;
    bb = b;
    c0 = 1'b0;
    case (op)
      SUB:     begin bb = ~b; c0 = 1'b1; end
      ADC:     begin bb = b;  c0 = cin;  end
      SBB:     begin bb = ~b; c0 = ~cin; end
      default: begin bb = b;  c0 = 1'b0; end
    endcase
    full = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
    ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    return {(full[31:0] == 32'd0), ovf, full[32], full[31:0]};
  endfunction

  // One isolated operation: accept at edge n, nothing after edge n+1, result after edge n+2.
  task automatic do_op(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [34:0] exp);
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; cin_i = cin; ready_i = 1'b1;
    #1 check({tag, "_ready"}, 64'(ready_o), 64'(1));
    @(posedge clk); #1;
    valid_i = 1'b0;
    check({tag, "_valid_n"}, 64'(valid_o), 64'(0));
    @(posedge clk); #1;
    check({tag, "_valid_n1"}, 64'(valid_o), 64'(0));
    @(posedge clk); #1;
    check({tag, "_valid_n2"}, 64'(valid_o), 64'(1));
    check({tag, "_result"}, 64'(res()), 64'(exp));
  endtask

  op_e         bp_op  [6];
  logic [31:0] bp_a   [6];
  logic [31:0] bp_b   [6];
  logic        bp_cin [6];
  logic [34:0] bp_exp [6];
  logic [34:0] exp_q  [$];

  initial begin
    int          idx;
    int          n_got;
    int          n_sent;
    logic        prev_stall;
    logic [35:0] held;
    logic [34:0] exp_v;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = ADD;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_flags", 64'(res()), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));

    do_op("add_wrap",  ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    do_op("sub_ovf",   SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});
    do_op("sub_neg",   SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    do_op("adc_ovf",   ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    do_op("sbb_brw",   SBB, 32'h0000_0000, 32'h0000_0000, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
    do_op("add_nocin", ADD, 32'h0000_0003, 32'h0000_0004, 1'b1, {1'b0, 1'b0, 1'b0, 32'h0000_0007});
    do_op("sub_zero",  SUB, 32'h0000_1234, 32'h0000_1234, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    do_op("add_ovf",   ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    do_op("adc_full",  ADC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF});
    do_op("sbb_nobrw", SBB, 32'h0000_0005, 32'h0000_0003, 1'b0, {1'b0, 1'b0, 1'b1, 32'h0000_0002});

    // Backpressure: six back-to-back ops, ready_i low in stream cycles 2..4.
    bp_op[0] = ADD; bp_a[0] = 32'h0000_0001; bp_b[0] = 32'h0000_0002; bp_cin[0] = 1'b0;
    bp_exp[0] = {1'b0, 1'b0, 1'b0, 32'h0000_0003};
    bp_op[1] = SUB; bp_a[1] = 32'h0000_000A; bp_b[1] = 32'h0000_0003; bp_cin[1] = 1'b0;
    bp_exp[1] = {1'b0, 1'b0, 1'b1, 32'h0000_0007};
    bp_op[2] = ADD; bp_a[2] = 32'h0000_FFFF; bp_b[2] = 32'h0000_0001; bp_cin[2] = 1'b0;
    bp_exp[2] = {1'b0, 1'b0, 1'b0, 32'h0001_0000};
    bp_op[3] = ADC; bp_a[3] = 32'h0F0F_0F0F; bp_b[3] = 32'hF0F0_F0F0; bp_cin[3] = 1'b1;
    bp_exp[3] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
    bp_op[4] = SBB; bp_a[4] = 32'h0000_0064; bp_b[4] = 32'h0000_0001; bp_cin[4] = 1'b1;
    bp_exp[4] = {1'b0, 1'b0, 1'b1, 32'h0000_0062};
    bp_op[5] = ADD; bp_a[5] = 32'h8000_0000; bp_b[5] = 32'h8000_0000; bp_cin[5] = 1'b0;
    bp_exp[5] = {1'b1, 1'b1, 1'b1, 32'h0000_0000};

    idx = 0; n_got = 0; prev_stall = 1'b0; held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && n_got < 6; cyc++) begin
      valid_i = (idx < 6);
      if (idx < 6) begin
        op_i = bp_op[idx]; a_i = bp_a[idx]; b_i = bp_b[idx]; cin_i = bp_cin[idx];
      end
      ready_i = !(cyc >= 2 && cyc <= 4);
      #1;
      if (prev_stall) check("bp_hold", 64'({valid_o, res()}), 64'(held));
      if (cyc == 3) check("bp_ready_low", 64'(ready_o), 64'(0));
      if (valid_o && ready_i) begin
        if (n_got < 6) check($sformatf("bp_res%0d", n_got), 64'(res()), 64'(bp_exp[n_got]));
        n_got++;
      end
      if (valid_i && ready_o) idx++;
      prev_stall = valid_o && !ready_i;
      held = {valid_o, res()};
      @(posedge clk); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("bp_count", 64'(n_got), 64'(6));

    // Reset with two operations in flight: one at the output, one behind it.
    valid_i = 1'b1; op_i = ADD; a_i = 32'd5; b_i = 32'd6; cin_i = 1'b0;
    @(posedge clk); #1;
    a_i = 32'd7; b_i = 32'd8;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", 64'(valid_o), 64'(1));
    check("rst_pre_sum", 64'(sum_o), 64'(11));
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_mid_valid", 64'(valid_o), 64'(0));
    check("rst_mid_sum", 64'(sum_o), 64'(0));
    for (int cyc = 0; cyc < 6; cyc++) begin
      check("rst_no_stale", 64'(valid_o), 64'(0));
      @(posedge clk); #1;
    end

    // Random operations and ready_i against the model.
    n_sent = 0; n_got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 4000 && n_got < 300; cyc++) begin
      valid_i = (n_sent < 300) && ($urandom_range(0, 3) != 0);
      op_i    = op_e'($urandom_range(0, 3));
      a_i     = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      b_i     = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      cin_i   = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 64'(valid_o), 64'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("rnd_res%0d", n_got), 64'(res()), 64'(exp_v));
        end
        n_got++;
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(op_i, a_i, b_i, cin_i));
        n_sent++;
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check("rnd_count", 64'(n_got), 64'(300));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
